// File: rtl/game_sequencer_pkg.sv
// Shared constants for the game-flow controller: state codes, default
// dwell times, wave ceiling and timer width.
package game_constants;

    localparam int TIMER_W            = 8;
    localparam int DEF_START_FRAMES   = 60;
    localparam int DEF_HIT_FRAMES     = 90;
    localparam int DEF_CLEAR_FRAMES   = 120;
    localparam int DEF_OVER_FRAMES    = 180;
    localparam int DEF_MAX_WAVE       = 7;

    typedef enum logic [2:0] {
        ST_ATTRACT     = 3'd0,
        ST_START_DELAY = 3'd1,
        ST_PLAYING     = 3'd2,
        ST_PLAYER_HIT  = 3'd3,
        ST_WAVE_CLEAR  = 3'd4,
        ST_GAME_OVER   = 3'd5
    } state_e;

    // Timer counts down to zero inclusive, so a dwell of N frames loads N-1.
    function automatic logic [TIMER_W-1:0] timer_load(input int n);
        return TIMER_W'(n - 1);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bus between the game-flow controller and the rest of the game logic.
interface game_sequencer_if;
    logic       frame;
    logic       start_btn;
    logic       player_hit;
    logic [1:0] lives;
    logic [5:0] invaders_left;
    logic       invaders_landed;
    logic [2:0] state;
    logic       run;
    logic       new_game;
    logic       new_wave;
    logic [2:0] wave;
    logic       show_title;
    logic       show_game_over;

    modport master (
        output frame, start_btn, player_hit, lives, invaders_left, invaders_landed,
        input  state, run, new_game, new_wave, wave, show_title, show_game_over
    );

    modport slave (
        input  frame, start_btn, player_hit, lives, invaders_left, invaders_landed,
        output state, run, new_game, new_wave, wave, show_title, show_game_over
    );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// Frame-paced down-counter. Expires on a frame where the count is already
// zero, giving a dwell of load_val+1 frames after the loading frame.
module frame_timer
    import game_constants::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               frame,
    output logic               expired
);

    logic [TIMER_W-1:0] r_cnt;

    // Load wins over decrement; count parks at zero between uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load)
            r_cnt <= load_val;
        else if (frame && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign expired = frame && (r_cnt == '0);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: title -> start delay -> play, with hit freeze,
// wave clear and game over. Everything advances only on frame strobes.
module game_sequencer
    import game_constants::*;
#(
    parameter int START_FRAMES = DEF_START_FRAMES,
    parameter int HIT_FRAMES   = DEF_HIT_FRAMES,
    parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES,
    parameter int OVER_FRAMES  = DEF_OVER_FRAMES,
    parameter int MAX_WAVE     = DEF_MAX_WAVE
)(
    input  logic             clk,
    input  logic             rst_n,
    game_sequencer_if.slave  io_bus
);

    localparam logic [2:0] W_MAX = 3'(MAX_WAVE);

    state_e             r_state, w_state_nxt;
    logic               r_btn_q, r_start_req, w_start;
    logic               w_load, w_expired, w_new_game, w_new_wave;
    logic [TIMER_W-1:0] w_load_val;
    logic               r_new_game, r_new_wave, r_run, r_show_title, r_show_go;
    logic [2:0]         r_wave;

    // A rising edge in the same clk as a frame counts for that frame.
    assign w_start = r_start_req | (io_bus.start_btn & ~r_btn_q);

    frame_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .frame    (io_bus.frame),
        .expired  (w_expired)
    );

    // Sticky start request; every frame either consumes or discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q     <= 1'b0;
            r_start_req <= 1'b0;
        end else begin
            r_btn_q <= io_bus.start_btn;
            if (io_bus.frame)
                r_start_req <= 1'b0;
            else if (io_bus.start_btn && !r_btn_q)
                r_start_req <= 1'b1;
        end
    end

    // Next-state, timer load and pulse requests; only frames move anything.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_new_game  = 1'b0;
        w_new_wave  = 1'b0;
        if (io_bus.frame) begin
            case (r_state)
                ST_ATTRACT: if (w_start) begin
                    w_state_nxt = ST_START_DELAY;
                    w_load      = 1'b1;
                    w_load_val  = timer_load(START_FRAMES);
                    w_new_game  = 1'b1;
                end
                ST_START_DELAY: if (w_expired) w_state_nxt = ST_PLAYING;
                ST_PLAYING: begin
                    if (io_bus.invaders_landed || (io_bus.lives == 2'd0) ||
                        (io_bus.player_hit && (io_bus.lives == 2'd1))) begin
                        w_state_nxt = ST_GAME_OVER;
                        w_load      = 1'b1;
                        w_load_val  = timer_load(OVER_FRAMES);
                    end else if (io_bus.player_hit) begin
                        w_state_nxt = ST_PLAYER_HIT;
                        w_load      = 1'b1;
                        w_load_val  = timer_load(HIT_FRAMES);
                    end else if (io_bus.invaders_left == 6'd0) begin
                        w_state_nxt = ST_WAVE_CLEAR;
                        w_load      = 1'b1;
                        w_load_val  = timer_load(CLEAR_FRAMES);
                    end
                end
                ST_PLAYER_HIT: if (w_expired) w_state_nxt = ST_PLAYING;
                ST_WAVE_CLEAR: if (w_expired) begin
                    w_state_nxt = ST_START_DELAY;
                    w_load      = 1'b1;
                    w_load_val  = timer_load(START_FRAMES);
                    w_new_wave  = 1'b1;
                end
                ST_GAME_OVER: if (w_expired) w_state_nxt = ST_ATTRACT;
                default: w_state_nxt = ST_ATTRACT;
            endcase
        end
    end

    // State, registered decodes, pulses and wave count all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ATTRACT;
            r_run        <= 1'b0;
            r_show_title <= 1'b1;
            r_show_go    <= 1'b0;
            r_new_game   <= 1'b0;
            r_new_wave   <= 1'b0;
            r_wave       <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_run        <= (w_state_nxt == ST_PLAYING);
            r_show_title <= (w_state_nxt == ST_ATTRACT);
            r_show_go    <= (w_state_nxt == ST_GAME_OVER);
            r_new_game   <= w_new_game;
            r_new_wave   <= w_new_wave;
            if (w_new_game)
                r_wave <= 3'd0;
            else if (w_new_wave)
                r_wave <= (r_wave >= W_MAX) ? W_MAX : r_wave + 3'd1;
        end
    end

    assign io_bus.state          = r_state;
    assign io_bus.run            = r_run;
    assign io_bus.new_game       = r_new_game;
    assign io_bus.new_wave       = r_new_wave;
    assign io_bus.wave           = r_wave;
    assign io_bus.show_title     = r_show_title;
    assign io_bus.show_game_over = r_show_go;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for the game-flow controller at default dwell times.
module tb_game_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_sequencer_if bus ();

    game_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ng_cnt  = 0;
    int   nw_cnt  = 0;
    int   ng_before, nw_before;
    logic ng_seen, nw_seen, ng_after, nw_after;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.new_game) ng_cnt <= ng_cnt + 1;
        if (bus.new_wave) nw_cnt <= nw_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame strobe, then three idle clks; records pulse levels in the
    // first cycle after the strobe and the cycle after that.
    task automatic frame_tick();
        @(negedge clk) bus.frame = 1'b1;
        @(negedge clk) bus.frame = 1'b0;
        ng_seen = bus.new_game;
        nw_seen = bus.new_wave;
        @(negedge clk);
        ng_after = bus.new_game;
        nw_after = bus.new_wave;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic start_game();
        @(negedge clk) bus.start_btn = 1'b1;
        @(negedge clk) bus.start_btn = 1'b0;
        frame_tick();
        chk("start_ng_pulse", ng_seen, 1);
        chk("start_ng_width", ng_after, 0);
        chk("start_state", bus.state, 1);
        chk("start_wave", bus.wave, 0);
        frames(59);
        chk("delay_hold", bus.state, 1);
        chk("delay_run", bus.run, 0);
        frame_tick();
        chk("play_state", bus.state, 2);
        chk("play_run", bus.run, 1);
    endtask

    task automatic clear_wave(input int exp_wave);
        bus.invaders_left = 6'd0;
        frame_tick();
        chk("clr_enter", bus.state, 4);
        bus.invaders_left = 6'd55;
        frames(119);
        chk("clr_hold", bus.state, 4);
        frame_tick();
        chk("clr_nw_pulse", nw_seen, 1);
        chk("clr_nw_width", nw_after, 0);
        chk("clr_wave", bus.wave, exp_wave);
        chk("clr_to_delay", bus.state, 1);
        frames(60);
        chk("clr_replay", bus.state, 2);
    endtask

    initial begin
        bus.frame           = 1'b0;
        bus.start_btn       = 1'b0;
        bus.player_hit      = 1'b0;
        bus.lives           = 2'd3;
        bus.invaders_left   = 6'd55;
        bus.invaders_landed = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_title", bus.show_title, 1);
        chk("rst_go", bus.show_game_over, 0);
        chk("rst_run", bus.run, 0);
        chk("rst_ng", bus.new_game, 0);
        chk("rst_nw", bus.new_wave, 0);
        chk("rst_wave", bus.wave, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            frame_tick();
            chk("idle_state", bus.state, 0);
            chk("idle_title", bus.show_title, 1);
            chk("idle_run", bus.run, 0);
        end

        start_game();

        // Hit with lives to spare: freeze then resume.
        bus.player_hit = 1'b1;
        frame_tick();
        bus.player_hit = 1'b0;
        chk("hit_state", bus.state, 3);
        chk("hit_run", bus.run, 0);
        frames(89);
        chk("hit_hold", bus.state, 3);
        frame_tick();
        chk("hit_back", bus.state, 2);
        chk("hit_run_back", bus.run, 1);

        // Nine waves cleared; wave saturates at 7.
        for (int w = 1; w <= 9; w++) clear_wave((w > 7) ? 7 : w);
        chk("nw_total", nw_cnt, 9);

        // Landing outranks hit and clear.
        bus.player_hit      = 1'b1;
        bus.invaders_left   = 6'd0;
        bus.invaders_landed = 1'b1;
        frame_tick();
        bus.player_hit      = 1'b0;
        bus.invaders_left   = 6'd55;
        bus.invaders_landed = 1'b0;
        chk("land_state", bus.state, 5);
        chk("land_go", bus.show_game_over, 1);
        chk("land_run", bus.run, 0);

        // Start pressed during game over must not auto-restart.
        @(negedge clk) bus.start_btn = 1'b1;
        @(negedge clk) bus.start_btn = 1'b0;
        frames(179);
        chk("over_hold", bus.state, 5);
        ng_before = ng_cnt;
        frame_tick();
        chk("over_to_attract", bus.state, 0);
        chk("over_title", bus.show_title, 1);
        frames(5);
        chk("no_restart", bus.state, 0);
        chk("no_restart_ng", ng_cnt, ng_before);

        // Start edge in the same clk as the frame is honoured; wave resets.
        @(negedge clk) begin bus.start_btn = 1'b1; bus.frame = 1'b1; end
        @(negedge clk) begin bus.start_btn = 1'b0; bus.frame = 1'b0; end
        chk("cofr_ng", bus.new_game, 1);
        chk("cofr_state", bus.state, 1);
        chk("cofr_wave", bus.wave, 0);
        @(negedge clk);
        @(negedge clk);
        frames(59);
        chk("cofr_hold", bus.state, 1);
        frame_tick();
        chk("cofr_play", bus.state, 2);

        // Hit and empty field together: hit wins.
        bus.player_hit    = 1'b1;
        bus.invaders_left = 6'd0;
        frame_tick();
        bus.player_hit    = 1'b0;
        bus.invaders_left = 6'd55;
        chk("hit_vs_clear", bus.state, 3);
        frames(90);
        chk("hit_vs_clear_back", bus.state, 2);

        // Last life lost.
        bus.lives      = 2'd1;
        bus.player_hit = 1'b1;
        frame_tick();
        bus.player_hit = 1'b0;
        bus.lives      = 2'd3;
        chk("last_life", bus.state, 5);
        frames(179);
        chk("last_hold", bus.state, 5);
        frame_tick();
        chk("last_attract", bus.state, 0);

        // Reset mid wave-clear, on the very frame that would end it.
        start_game();
        clear_wave(1);
        bus.invaders_left = 6'd0;
        frame_tick();
        bus.invaders_left = 6'd55;
        chk("rmid_enter", bus.state, 4);
        frames(119);
        nw_before = nw_cnt;
        @(negedge clk) begin bus.frame = 1'b1; rst_n = 1'b0; end
        #1;
        chk("rmid_state", bus.state, 0);
        chk("rmid_title", bus.show_title, 1);
        chk("rmid_run", bus.run, 0);
        chk("rmid_wave", bus.wave, 0);
        chk("rmid_nw", bus.new_wave, 0);
        @(negedge clk) bus.frame = 1'b0;
        chk("rmid_nw_next", bus.new_wave, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frames(3);
        chk("rmid_nw_cnt", nw_cnt, nw_before);
        chk("rmid_after", bus.state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for Space Invaders. It sequences a session through title, start delay, play, hit freeze, wave clear and game over. It gates all per-frame motion through a single `run` enable, and issues the one-cycle `new_game` / `new_wave` pulses that reinitialise the score/lives keeper and the invader field. It sits between the collision/score logic and the sprite movers, and advances only on `frame` strobes.

## Interface
Parameters:
- `START_FRAMES`, 60: frames spent in START_DELAY before play begins
- `HIT_FRAMES`, 90: frames frozen after the player is hit
- `CLEAR_FRAMES`, 120: frames paused after a wave is cleared
- `OVER_FRAMES`, 180: frames the game-over screen is held
- `MAX_WAVE`, 7: saturation value of `wave`

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `frame` in 1: one-clk pulse per video frame
- `start_btn` in 1: debounced start button (level)
- `player_hit` in 1: player collision this frame (sampled on `frame`)
- `lives` in 2: current lives from the score keeper
- `invaders_left` in 6: live invader count, 0..55
- `invaders_landed` in 1: an invader has reached the player row
- `state` out 3: current state encoding
- `run` out 1: game objects advance on this frame
- `new_game` out 1: one-clk pulse that resets score, lives, wave and invaders
- `new_wave` out 1: one-clk pulse that respawns the invader field
- `wave` out 3: current wave number, 0-based
- `show_title` out 1: high in ATTRACT
- `show_game_over` out 1: high in GAME_OVER

## Operation
- States: ATTRACT=0, START_DELAY=1, PLAYING=2, PLAYER_HIT=3, WAVE_CLEAR=4, GAME_OVER=5. Codes 6 and 7 are illegal and recover to ATTRACT on the next `frame`.
- Start latch: a rising edge of `start_btn`, detected every clk, sets a sticky `start_req`.
  - `start_req` is cleared when consumed.
  - Any `start_req` raised outside ATTRACT is cleared on the next `frame`.
- All state transitions and timer updates happen only in clk cycles where `frame`=1.
- ATTRACT, when `start_req` is set: go to START_DELAY and pulse `new_game`.
- START_DELAY: go to PLAYING when the timer expires.
- PLAYING: conditions are evaluated in priority order.
  1. `invaders_landed`, or `lives`==0, or (`player_hit` and `lives`==1): go to GAME_OVER.
  2. `player_hit`: go to PLAYER_HIT.
  3. `invaders_left`==0: go to WAVE_CLEAR.
- PLAYER_HIT: go to PLAYING when the timer expires.
- WAVE_CLEAR: when the timer expires, go to START_DELAY, pulse `new_wave`, and set `wave` to min(`wave`+1, `MAX_WAVE`).
- GAME_OVER: go to ATTRACT when the timer expires. `start_btn` is ignored in this state.
- Timer:
  - 8-bit down-counter, loaded with N-1 on entry to a timed state, where N is that state's parameter.
  - Decrements on each `frame`.
  - Expires on a `frame` where the count is 0, so dwell is exactly N frames.
  - Parameters are restricted to 1..256.
- `run` = 1 only in PLAYING (registered state decode).
- `wave` clears to 0 on `new_game` and saturates at `MAX_WAVE`.

## Timing
- Reset values: `state`=ATTRACT, `run`=0, `new_game`=0, `new_wave`=0, `wave`=0, `show_title`=1, `show_game_over`=0, timer=0, `start_req`=0.
- `state` and the decoded outputs change in the clk after the qualifying `frame` cycle.
- `new_game` and `new_wave` are high for exactly one clk, coincident with the first cycle of the new state. They never assert in the same cycle.
- Start-edge latency: one clk to `start_req`, then up to one frame period to leave ATTRACT.
- A `start_btn` edge and a `frame` in the same clk: the edge counts for that frame.
- `rst_n` asserted mid-operation forces all reset values immediately. Any pending pulse is dropped.
- Simultaneous `player_hit` and `invaders_left`==0: the hit wins.

## Structure
- Shared constants package/include `game_constants`: state encodings, default frame counts, `MAX_WAVE`, timer width.
- One sub-module, `frame_timer`:
  - Inputs: `load`, `load_val[7:0]`, `frame`.
  - Output: `expired`.
  - Same clock and reset as the parent.
- The FSM, start edge detector, wave counter and output decode live in the parent.

## Test plan
- Reset, then hold idle: `state`=0, `show_title`=1, `run`=0 for 10 frames.
- Pulse `start_btn` in ATTRACT: `new_game` high for 1 clk, `state`=1, and `state`=2 with `run`=1 exactly 60 frames later.
- In PLAYING with `lives`=3, assert `player_hit` on a frame: `state`=3 and `run`=0 for 90 frames, then back to 2. Repeat with `lives`=1: `state`=5, then 180 frames later `state`=0.
- In PLAYING, drive `invaders_left`=0: `state`=4 for 120 frames, then `new_wave` pulse, `wave`=1, `state`=1. Clear 9 waves: `wave` holds at 7.
- In PLAYING, assert `player_hit`, `invaders_left`=0 and `invaders_landed` together: `state`=5. Drop `invaders_landed`: `state`=3.
- Assert `rst_n` low mid-WAVE_CLEAR: all outputs return to reset values within the same clk and no `new_wave` pulse occurs. Pulse `start_btn` during GAME_OVER: ATTRACT is reached with no automatic restart.
